// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the timing generator and the video pipeline that consumes it.
// The generator sits on the master side. It owns every timing output and takes pix_ce/resync from the slave.
interface vga_timing_gen_if #(
   parameter int COUNT_W = 10,
   parameter int LINE_W  = 11,
   parameter int FRAME_W = 11
);
   // pix_ce is a one-clock advance qualifier with no back-pressure. The generator consumes
   // every cycle in which it is high. resync has the same single-cycle meaning.
   logic               pix_ce;
   logic               resync;
   logic [COUNT_W-1:0] hCount;
   logic [COUNT_W-1:0] vCount;
   logic               visible;
   logic               hFront;
   logic               hSync;
   logic               hBack;
   logic               vFront;
   logic               vSync;
   logic               vBack;
   logic               hsync_pin;
   logic               vsync_pin;
   logic               line_start;
   logic               frame_start;
   logic [LINE_W-1:0]  lines;
   logic [FRAME_W-1:0] frames;

   modport master (
      input  pix_ce, resync,
      output hCount, vCount, visible, hFront, hSync, hBack, vFront, vSync, vBack,
             hsync_pin, vsync_pin, line_start, frame_start, lines, frames
   );

   modport slave (
      output pix_ce, resync,
      input  hCount, vCount, visible, hFront, hSync, hBack, vFront, vSync, vBack,
             hsync_pin, vsync_pin, line_start, frame_start, lines, frames
   );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator. It steps one pixel per pix_ce and registers every output.
// Flags are decoded from the next counter value, so they line up with the counters shown in the same cycle.
module vga_timing_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0,
   parameter int COUNT_W   = 10,
   parameter int LINE_W    = 11,
   parameter int FRAME_W   = 11
) (
   input  logic             clk,
   input  logic             reset,
   vga_timing_gen_if.master tim
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam logic [COUNT_W-1:0] H_LAST = COUNT_W'(H_TOTAL - 1);
   localparam logic [COUNT_W-1:0] V_LAST = COUNT_W'(V_TOTAL - 1);

   // Returns {front, sync, back}. The comparisons are done in int so that a phase ending at the
   // total cannot overflow COUNT_W. A zero-length phase gives an empty range and never asserts.
   function automatic logic [2:0] phaseOf(input int pos, input int vis, input int front,
                                          input int sync, input int back);
      logic [2:0] f;
      f[2] = (pos >= vis) && (pos < vis + front);
      f[1] = (pos >= vis + front) && (pos < vis + front + sync);
      f[0] = (pos >= vis + front + sync) && (pos < vis + front + sync + back);
      return f;
   endfunction

   logic [COUNT_W-1:0] hCountQ, vCountQ, hNext, vNext;
   logic [LINE_W-1:0]  linesQ, linesNext;
   logic [FRAME_W-1:0] framesQ, framesNext;
   logic               lineStartNext, frameStartNext;
   logic               visibleQ;
   logic [2:0]         hPhaseQ, vPhaseQ, hPhaseNext, vPhaseNext;
   logic               hsyncPinQ, vsyncPinQ, lineStartQ, frameStartQ;

   always_comb begin
      hNext          = hCountQ;
      vNext          = vCountQ;
      linesNext      = linesQ;
      framesNext     = framesQ;
      lineStartNext  = 1'b0;
      frameStartNext = 1'b0;
      if (tim.resync) begin
         // Restart the raster but keep the line and frame statistics.
         hNext          = '0;
         vNext          = '0;
         lineStartNext  = 1'b1;
         frameStartNext = 1'b1;
      end else if (tim.pix_ce) begin
         if (hCountQ == H_LAST) begin
            hNext         = '0;
            linesNext     = linesQ + LINE_W'(1);
            lineStartNext = 1'b1;
            if (vCountQ == V_LAST) begin
               vNext          = '0;
               framesNext     = framesQ + FRAME_W'(1);
               frameStartNext = 1'b1;
            end else begin
               vNext = vCountQ + COUNT_W'(1);
            end
         end else begin
            hNext = hCountQ + COUNT_W'(1);
         end
      end
   end

   always_comb begin
      hPhaseNext = phaseOf(int'(hNext), H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
      vPhaseNext = phaseOf(int'(vNext), V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hCountQ     <= '0;
         vCountQ     <= '0;
         visibleQ    <= 1'b1;
         hPhaseQ     <= '0;
         vPhaseQ     <= '0;
         hsyncPinQ   <= ~HSYNC_POL;
         vsyncPinQ   <= ~VSYNC_POL;
         lineStartQ  <= 1'b0;
         frameStartQ <= 1'b0;
         linesQ      <= '0;
         framesQ     <= '0;
      end else begin
         hCountQ     <= hNext;
         vCountQ     <= vNext;
         visibleQ    <= (int'(hNext) < H_VISIBLE) && (int'(vNext) < V_VISIBLE);
         hPhaseQ     <= hPhaseNext;
         vPhaseQ     <= vPhaseNext;
         hsyncPinQ   <= hPhaseNext[1] ? HSYNC_POL : ~HSYNC_POL;
         vsyncPinQ   <= vPhaseNext[1] ? VSYNC_POL : ~VSYNC_POL;
         lineStartQ  <= lineStartNext;
         frameStartQ <= frameStartNext;
         linesQ      <= linesNext;
         framesQ     <= framesNext;
      end
   end

   assign tim.hCount      = hCountQ;
   assign tim.vCount      = vCountQ;
   assign tim.visible     = visibleQ;
   assign tim.hFront      = hPhaseQ[2];
   assign tim.hSync       = hPhaseQ[1];
   assign tim.hBack       = hPhaseQ[0];
   assign tim.vFront      = vPhaseQ[2];
   assign tim.vSync       = vPhaseQ[1];
   assign tim.vBack       = vPhaseQ[0];
   assign tim.hsync_pin   = hsyncPinQ;
   assign tim.vsync_pin   = vsyncPinQ;
   assign tim.line_start  = lineStartQ;
   assign tim.frame_start = frameStartQ;
   assign tim.lines       = linesQ;
   assign tim.frames      = framesQ;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a small raster instance (A) for the directed scenarios and a default 640x480
// instance (B) for the first few lines. Both instances are compared every cycle against a position-index model.
module tb_vga_timing_gen;

   localparam int A_HV = 4, A_HF = 1, A_HS = 2, A_HB = 1;
   localparam int A_VV = 3, A_VF = 1, A_VS = 1, A_VB = 1;
   localparam int A_HT = 8, A_VT = 6, A_FT = 48;
   localparam int B_HT = 800, B_VT = 525, B_FT = 420000;

   logic clk = 1'b0;
   logic rstA = 1'b1;
   logic rstB = 1'b1;
   int   total = 0;
   int   bad = 0;

   vga_timing_gen_if #(.COUNT_W(4), .LINE_W(4), .FRAME_W(2)) busA ();
   vga_timing_gen_if busB ();

   vga_timing_gen #(
      .H_VISIBLE(A_HV), .H_FRONT(A_HF), .H_SYNC(A_HS), .H_BACK(A_HB),
      .V_VISIBLE(A_VV), .V_FRONT(A_VF), .V_SYNC(A_VS), .V_BACK(A_VB),
      .HSYNC_POL(1'b1), .VSYNC_POL(1'b0),
      .COUNT_W(4), .LINE_W(4), .FRAME_W(2)
   ) dutA (.clk(clk), .reset(rstA), .tim(busA));

   vga_timing_gen dutB (.clk(clk), .reset(rstB), .tim(busB));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // 0 = visible, 1 = front, 2 = sync, 3 = back
   function automatic int phase(input int x, input int vis, input int fr, input int sy);
      if (x < vis) return 0;
      if (x < vis + fr) return 1;
      if (x < vis + fr + sy) return 2;
      return 3;
   endfunction

   // Model: the raster is a linear pixel index inside the frame, with line and frame tallies.
   int aPos = 0, aLines = 0, aFrames = 0;
   bit aLs = 0, aFs = 0, aValid = 0;
   int bPos = 0;
   bit bLs = 0, bFs = 0, bValid = 0;

   always @(posedge clk) begin
      if (rstA) begin
         aPos <= 0; aLines <= 0; aFrames <= 0; aLs <= 0; aFs <= 0; aValid <= 1;
      end else if (busA.resync) begin
         aPos <= 0; aLs <= 1; aFs <= 1;
      end else if (busA.pix_ce) begin
         aPos    <= (aPos + 1) % A_FT;
         aLs     <= ((aPos + 1) % A_HT) == 0;
         aFs     <= ((aPos + 1) % A_FT) == 0;
         aLines  <= (((aPos + 1) % A_HT) == 0) ? (aLines + 1) % 16 : aLines;
         aFrames <= (((aPos + 1) % A_FT) == 0) ? (aFrames + 1) % 4 : aFrames;
      end else begin
         aLs <= 0; aFs <= 0;
      end
      if (rstB) begin
         bPos <= 0; bLs <= 0; bFs <= 0; bValid <= 1;
      end else if (busB.pix_ce) begin
         bPos <= (bPos + 1) % B_FT;
         bLs  <= ((bPos + 1) % B_HT) == 0;
         bFs  <= ((bPos + 1) % B_FT) == 0;
      end else begin
         bLs <= 0; bFs <= 0;
      end
   end

   always @(negedge clk) begin
      if (aValid) begin
         int h, v, ph, pv;
         h = aPos % A_HT; v = aPos / A_HT;
         ph = phase(h, A_HV, A_HF, A_HS); pv = phase(v, A_VV, A_VF, A_VS);
         chk("A.hCount", 32'(busA.hCount), 32'(h));
         chk("A.vCount", 32'(busA.vCount), 32'(v));
         chk("A.visible", 32'(busA.visible), 32'(ph == 0 && pv == 0));
         chk("A.hFront", 32'(busA.hFront), 32'(ph == 1));
         chk("A.hSync", 32'(busA.hSync), 32'(ph == 2));
         chk("A.hBack", 32'(busA.hBack), 32'(ph == 3));
         chk("A.vFront", 32'(busA.vFront), 32'(pv == 1));
         chk("A.vSync", 32'(busA.vSync), 32'(pv == 2));
         chk("A.vBack", 32'(busA.vBack), 32'(pv == 3));
         chk("A.hsync_pin", 32'(busA.hsync_pin), 32'(ph == 2));
         chk("A.vsync_pin", 32'(busA.vsync_pin), 32'(pv != 2));
         chk("A.line_start", 32'(busA.line_start), 32'(aLs));
         chk("A.frame_start", 32'(busA.frame_start), 32'(aFs));
         chk("A.lines", 32'(busA.lines), 32'(aLines));
         chk("A.frames", 32'(busA.frames), 32'(aFrames));
         chk("A.onehotH", 32'($onehot0({busA.hFront, busA.hSync, busA.hBack})), 32'd1);
         chk("A.onehotV", 32'($onehot0({busA.vFront, busA.vSync, busA.vBack})), 32'd1);
      end
      if (bValid) begin
         int h, v, ph, pv;
         h = bPos % B_HT; v = bPos / B_HT;
         ph = phase(h, 640, 16, 96); pv = phase(v, 480, 10, 2);
         chk("B.hCount", 32'(busB.hCount), 32'(h));
         chk("B.vCount", 32'(busB.vCount), 32'(v));
         chk("B.visible", 32'(busB.visible), 32'(ph == 0 && pv == 0));
         chk("B.hFront", 32'(busB.hFront), 32'(ph == 1));
         chk("B.hSync", 32'(busB.hSync), 32'(ph == 2));
         chk("B.hBack", 32'(busB.hBack), 32'(ph == 3));
         chk("B.vSync", 32'(busB.vSync), 32'(pv == 2));
         chk("B.hsync_pin", 32'(busB.hsync_pin), 32'(ph != 2));
         chk("B.vsync_pin", 32'(busB.vsync_pin), 32'(pv != 2));
         chk("B.line_start", 32'(busB.line_start), 32'(bLs));
         chk("B.frame_start", 32'(busB.frame_start), 32'(bFs));
         chk("B.onehotH", 32'($onehot0({busB.hFront, busB.hSync, busB.hBack})), 32'd1);
      end
   end

   // Drivers: called at a falling edge, apply inputs, return at the next falling edge.
   task automatic stepA(input bit p, input bit r);
      busA.pix_ce = p;
      busA.resync = r;
      @(negedge clk);
   endtask

   task automatic resetA();
      rstA = 1'b1;
      busA.pix_ce = 1'b0;
      busA.resync = 1'b0;
      @(negedge clk);
      rstA = 1'b0;
   endtask

   task automatic chkResetA(input string tag);
      chk({tag, ".hCount"}, 32'(busA.hCount), 32'd0);
      chk({tag, ".vCount"}, 32'(busA.vCount), 32'd0);
      chk({tag, ".visible"}, 32'(busA.visible), 32'd1);
      chk({tag, ".flags"}, 32'({busA.hFront, busA.hSync, busA.hBack, busA.vFront, busA.vSync, busA.vBack}), 32'd0);
      chk({tag, ".pins"}, 32'({busA.hsync_pin, busA.vsync_pin}), 32'b01);
      chk({tag, ".strobes"}, 32'({busA.line_start, busA.frame_start}), 32'd0);
      chk({tag, ".lines"}, 32'(busA.lines), 32'd0);
      chk({tag, ".frames"}, 32'(busA.frames), 32'd0);
   endtask

   initial begin
      busA.pix_ce = 1'b0;
      busA.resync = 1'b0;
      busB.pix_ce = 1'b1;
      busB.resync = 1'b0;
      fork
         begin : seqA
            int fsSeen, nLs, firstLs, secondLs, nFs;
            int expFrames[5];
            expFrames = '{1, 2, 3, 0, 1};
            @(negedge clk);
            resetA();
            chkResetA("rst0");

            // One full small frame.
            fsSeen = 0;
            repeat (48) begin
               stepA(1, 0);
               fsSeen += int'(busA.frame_start);
            end
            chk("frame48.frames", 32'(busA.frames), 32'd1);
            chk("frame48.lines", 32'(busA.lines), 32'd6);
            chk("frame48.h", 32'(busA.hCount), 32'd0);
            chk("frame48.v", 32'(busA.vCount), 32'd0);
            chk("frame48.fsSeen", 32'(fsSeen), 32'd1);

            // pix_ce every 3rd clock: line period 24.
            nLs = 0; firstLs = -1; secondLs = -1;
            for (int i = 0; i < 60; i++) begin
               stepA(i % 3 == 0, 0);
               if (busA.line_start) begin
                  if (nLs == 0) firstLs = i;
                  else if (nLs == 1) secondLs = i;
                  nLs++;
               end
            end
            chk("ce3.count", 32'(nLs), 32'd2);
            chk("ce3.period", 32'(secondLs - firstLs), 32'd24);

            // Resync at (5,4).
            resetA();
            repeat (37) stepA(1, 0);
            chk("pre.h", 32'(busA.hCount), 32'd5);
            chk("pre.v", 32'(busA.vCount), 32'd4);
            chk("pre.syncs", 32'({busA.hSync, busA.vSync}), 32'b11);
            stepA(1, 1);
            chk("resync.h", 32'(busA.hCount), 32'd0);
            chk("resync.v", 32'(busA.vCount), 32'd0);
            chk("resync.strobes", 32'({busA.line_start, busA.frame_start}), 32'b11);
            chk("resync.lines", 32'(busA.lines), 32'd4);
            chk("resync.frames", 32'(busA.frames), 32'd0);
            stepA(0, 0);
            chk("resync.strobeEnd", 32'({busA.line_start, busA.frame_start}), 32'b00);

            // Reset while in vSync, with pix_ce still high.
            resetA();
            repeat (35) stepA(1, 0);
            chk("midsync.vSync", 32'(busA.vSync), 32'd1);
            rstA = 1'b1;
            busA.pix_ce = 1'b1;
            @(negedge clk);
            chkResetA("rstMid");
            rstA = 1'b0;
            repeat (10) stepA(1, 0);
            chk("resume.h", 32'(busA.hCount), 32'd2);
            chk("resume.v", 32'(busA.vCount), 32'd1);
            chk("resume.lines", 32'(busA.lines), 32'd1);

            // Five frames with a 2-bit frame counter.
            resetA();
            nFs = 0;
            repeat (240) begin
               stepA(1, 0);
               if (busA.frame_start) begin
                  if (nFs < 5) chk("wrap.frames", 32'(busA.frames), 32'(expFrames[nFs]));
                  nFs++;
               end
            end
            chk("wrap.count", 32'(nFs), 32'd5);
            chk("wrap.lines", 32'(busA.lines), 32'd14);
         end
         begin : seqB
            int firstLs, secondLs, nLs, syncLen, syncStart;
            @(negedge clk);
            @(negedge clk);
            rstB = 1'b0;
            firstLs = -1; secondLs = -1; nLs = 0; syncLen = 0; syncStart = -1;
            for (int i = 0; i < 2500; i++) begin
               @(negedge clk);
               if (busB.line_start) begin
                  if (nLs == 0) firstLs = i;
                  else if (nLs == 1) secondLs = i;
                  nLs++;
               end
               if (nLs == 0 && busB.hSync) begin
                  if (syncStart < 0) syncStart = int'(busB.hCount);
                  syncLen++;
               end
            end
            chk("B.lsCount", 32'(nLs), 32'd3);
            chk("B.lsPeriod", 32'(secondLs - firstLs), 32'd800);
            chk("B.syncStart", 32'(syncStart), 32'd656);
            chk("B.syncLen", 32'(syncLen), 32'd96);
         end
      join
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
